// File: rtl/cpu_pkg.sv
// Shared core constants: CDB widths, execution-unit indices and the broadcast bus layout.
package cpu_pkg;

   localparam int NREQ   = 4;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;

   localparam int UNIT_ALU = 0;
   localparam int UNIT_LS  = 1;
   localparam int UNIT_MUL = 2;
   localparam int UNIT_DIV = 3;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic              branch;
      logic              taken;
   } cdb_bus_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests by the pointer, take the lowest set bit,
// rotate the index back. Returns the one-hot grant, its index and whether anything was pending.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   localparam logic [PW:0] N_W = (PW+1)'(N);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [PW-1:0]  off;
   logic [PW:0]    sum;

   always_comb begin
      dbl = {req_i, req_i};
      rot = dbl[ptr_i +: N];
      off = '0;
      // scan downward so the lowest set bit (closest to the pointer) wins
      for (int k = N-1; k >= 0; k--) begin
         if (rot[k]) off = PW'(k);
      end
      sum = {1'b0, ptr_i} + {1'b0, off};
      if (sum >= N_W) sum = sum - N_W;
      idx_o = sum[PW-1:0];
      any_o = |req_i;
      gnt_o = any_o ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the Common Data Bus between the execution units; one
// result per clock, broadcast from a register one cycle after the handshake.
module cdb_arbiter #(
   parameter int NREQ   = cpu_pkg::NREQ,
   parameter int TAG_W  = cpu_pkg::TAG_W,
   parameter int DATA_W = cpu_pkg::DATA_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*TAG_W-1:0]    req_tag,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   input  logic [NREQ-1:0]          req_branch,
   input  logic [NREQ-1:0]          req_branch_taken,
   output logic [NREQ-1:0]          req_ready,
   output logic                     Cdb_valid,
   output logic [TAG_W-1:0]         Cdb_rd_tag,
   output logic [DATA_W-1:0]        Cdb_data,
   output logic                     Cdb_branch,
   output logic                     Cdb_branch_taken,
   output logic [1:0]               Cdb_src
);

   import cpu_pkg::*;

   localparam int            PW   = $clog2(NREQ);
   localparam logic [PW-1:0] LAST = PW'(NREQ-1);

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic              branch;
      logic              taken;
   } bus_t;

   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   bus_t            cdb_q, cdb_d;
   logic [1:0]      src_q, src_d;

   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_any;
   logic            xfer;

   rr_pick #(.N(NREQ), .PW(PW)) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   // ready is held low through reset and flush so no unit sees a phantom handshake
   assign xfer      = gnt_any & ~flush & ~reset;
   assign req_ready = xfer ? gnt : '0;

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      cdb_d     = cdb_q;
      cdb_d.valid = 1'b0;
      src_d     = src_q;
      if (xfer) begin
         rr_ptr_d     = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
         cdb_d.valid  = 1'b1;
         cdb_d.tag    = req_tag[gnt_idx*TAG_W +: TAG_W];
         cdb_d.data   = req_data[gnt_idx*DATA_W +: DATA_W];
         cdb_d.branch = req_branch[gnt_idx];
         cdb_d.taken  = req_branch_taken[gnt_idx];
         src_d        = 2'(gnt_idx);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= '0;
         cdb_q    <= '0;
         src_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cdb_q    <= cdb_d;
         src_q    <= src_d;
      end
   end

   assign Cdb_valid        = cdb_q.valid;
   assign Cdb_rd_tag       = cdb_q.tag;
   assign Cdb_data         = cdb_q.data;
   assign Cdb_branch       = cdb_q.branch;
   assign Cdb_branch_taken = cdb_q.taken;
   assign Cdb_src          = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: stimulus pushes hand-computed broadcasts,
// a negedge monitor pops and compares whenever the CDB is valid.
module tb_cdb_arbiter;
   import cpu_pkg::*;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic                     flush = 1'b0;
   logic [NREQ-1:0]          req_valid = '0;
   logic [NREQ*TAG_W-1:0]    req_tag = '0;
   logic [NREQ*DATA_W-1:0]   req_data = '0;
   logic [NREQ-1:0]          req_branch = '0;
   logic [NREQ-1:0]          req_branch_taken = '0;
   logic [NREQ-1:0]          req_ready;
   logic                     Cdb_valid;
   logic [TAG_W-1:0]         Cdb_rd_tag;
   logic [DATA_W-1:0]        Cdb_data;
   logic                     Cdb_branch;
   logic                     Cdb_branch_taken;
   logic [1:0]               Cdb_src;

   cdb_arbiter dut (
      .clock            (clock),
      .reset            (reset),
      .flush            (flush),
      .req_valid        (req_valid),
      .req_tag          (req_tag),
      .req_data         (req_data),
      .req_branch       (req_branch),
      .req_branch_taken (req_branch_taken),
      .req_ready        (req_ready),
      .Cdb_valid        (Cdb_valid),
      .Cdb_rd_tag       (Cdb_rd_tag),
      .Cdb_data         (Cdb_data),
      .Cdb_branch       (Cdb_branch),
      .Cdb_branch_taken (Cdb_branch_taken),
      .Cdb_src          (Cdb_src)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      cdb_bus_t   bus;
      logic [1:0] src;
   } exp_t;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   int   gq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_req(input int u, input int tag, input int data, input bit br, input bit tk);
      req_tag[u*TAG_W +: TAG_W]    = TAG_W'(tag);
      req_data[u*DATA_W +: DATA_W] = DATA_W'(data);
      req_branch[u]       = br;
      req_branch_taken[u] = tk;
      req_valid[u]        = 1'b1;
   endtask

   task automatic exp_push(input int tag, input int data, input bit br, input bit tk, input int src);
      exp_t e;
      e.bus.valid  = 1'b1;
      e.bus.tag    = TAG_W'(tag);
      e.bus.data   = DATA_W'(data);
      e.bus.branch = br;
      e.bus.taken  = tk;
      e.src        = 2'(src);
      sb.push_back(e);
   endtask

   // Entered between posedge+1 and the negedge; serves pending units until none is valid.
   task automatic run_drain(input int budget);
      int               c;
      logic [NREQ-1:0]  g;
      int               gi;
      c = 0;
      while (req_valid != '0) begin
         if (c == budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: valid %b still pending after %0d cycles", req_valid, budget);
            req_valid = '0;
            break;
         end
         @(negedge clock);
         g  = req_ready;
         gi = -1;
         for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
         if (gi >= 0) gq.push_back(gi);
         @(posedge clock);
         #1;
         if (gi >= 0) begin
            chk("lat_valid", 64'(Cdb_valid), 64'd1);
            chk("lat_src", 64'(Cdb_src), 64'(gi));
         end
         req_valid = req_valid & ~g;
         c++;
      end
   endtask

   // seq lists expected grants, first grant in the most significant used nibble.
   task automatic chk_grants(input string nm, input int n, input logic [31:0] seq);
      chk({nm, "_count"}, 64'(gq.size()), 64'(n));
      for (int k = 0; k < n && gq.size() > 0; k++) begin
         chk(nm, 64'(gq.pop_front()), 64'(seq[4*(n-1-k) +: 4]));
      end
      gq.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         chk("onehot", 64'($onehot0(req_ready)), 64'd1);
         if (Cdb_valid) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL cdb_unexpected: tag %0d src %0d broadcast, none expected", Cdb_rd_tag, Cdb_src);
            end else begin
               e = sb.pop_front();
               chk("cdb_tag",    64'(Cdb_rd_tag),       64'(e.bus.tag));
               chk("cdb_data",   64'(Cdb_data),         64'(e.bus.data));
               chk("cdb_branch", 64'(Cdb_branch),       64'(e.bus.branch));
               chk("cdb_taken",  64'(Cdb_branch_taken), 64'(e.bus.taken));
               chk("cdb_src",    64'(Cdb_src),          64'(e.src));
            end
         end
      end
   end

   // Payload must stay put while a unit waits for ready
   logic [NREQ-1:0]        pend_q = '0;
   logic [NREQ*TAG_W-1:0]  ptag_q = '0;
   logic [NREQ*DATA_W-1:0] pdata_q = '0;
   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) begin
            if (pend_q[i] && req_valid[i]) begin
               chk("stable_tag",  64'(req_tag[i*TAG_W +: TAG_W]),   64'(ptag_q[i*TAG_W +: TAG_W]));
               chk("stable_data", 64'(req_data[i*DATA_W +: DATA_W]), 64'(pdata_q[i*DATA_W +: DATA_W]));
            end
         end
      end
      pend_q  <= reset ? '0 : (req_valid & ~req_ready);
      ptag_q  <= req_tag;
      pdata_q <= req_data;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ftag [4] = '{11, 12, 13, 14};
      int fdata[4] = '{110, 120, 130, 140};
      int u;

      // Reset state, with a unit requesting under reset
      repeat (2) @(posedge clock);
      #1;
      set_req(UNIT_ALU, 5, 50, 0, 0);
      @(negedge clock);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_valid", 64'(Cdb_valid), 64'd0);
      chk("rst_tag",   64'(Cdb_rd_tag), 64'd0);
      chk("rst_data",  64'(Cdb_data), 64'd0);
      chk("rst_src",   64'(Cdb_src), 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("a_ready", 64'(req_ready), 64'b0001);
      @(posedge clock);
      #1;
      chk("a_bcast_up", 64'(Cdb_valid), 64'd1);
      chk("a_bcast_tag", 64'(Cdb_rd_tag), 64'd5);
      req_valid[0] = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("a_async_valid", 64'(Cdb_valid), 64'd0);
      chk("a_async_tag", 64'(Cdb_rd_tag), 64'd0);
      set_req(UNIT_ALU, 7, 70, 0, 0);
      set_req(UNIT_LS, 8, 80, 0, 0);
      @(negedge clock);
      chk("a_rst_ready", 64'(req_ready), 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      exp_push(7, 70, 0, 0, 0);
      exp_push(8, 80, 0, 0, 1);
      run_drain(8);
      chk_grants("a_order", 2, {4'd0, 4'd1});

      // Outputs hold while idle
      idle(2);
      chk("hold_valid", 64'(Cdb_valid), 64'd0);
      chk("hold_tag", 64'(Cdb_rd_tag), 64'd8);
      chk("hold_data", 64'(Cdb_data), 64'd80);
      chk("hold_src", 64'(Cdb_src), 64'd1);

      // Branch pass-through, then flush while that broadcast is on the bus
      set_req(UNIT_ALU, 9, 90, 1, 1);
      exp_push(9, 90, 1, 1, 0);
      @(negedge clock);
      chk("b_ready", 64'(req_ready), 64'b0001);
      @(posedge clock);
      #1;
      req_valid[0] = 1'b0;
      set_req(UNIT_LS, 21, 210, 0, 0);
      set_req(UNIT_DIV, 23, 230, 1, 0);
      flush = 1'b1;
      @(negedge clock);
      chk("f_ready", 64'(req_ready), 64'd0);
      chk("f_bcast_kept", 64'(Cdb_valid), 64'd1);
      @(posedge clock);
      #1 flush = 1'b0;
      #1;
      chk("f_cdb_off", 64'(Cdb_valid), 64'd0);
      chk("f_ready_ptr", 64'(req_ready), 64'b0010);
      exp_push(21, 210, 0, 0, 1);
      exp_push(23, 230, 1, 0, 3);
      run_drain(8);
      chk_grants("f_order", 2, {4'd1, 4'd3});

      // All four at once, back to back
      set_req(UNIT_ALU, 1, 10, 0, 0);
      set_req(UNIT_LS,  2, 20, 0, 0);
      set_req(UNIT_MUL, 3, 30, 0, 0);
      set_req(UNIT_DIV, 4, 40, 0, 0);
      exp_push(1, 10, 0, 0, 0);
      exp_push(2, 20, 0, 0, 1);
      exp_push(3, 30, 0, 0, 2);
      exp_push(4, 40, 0, 0, 3);
      run_drain(8);
      chk_grants("all4_order", 4, {4'd0, 4'd1, 4'd2, 4'd3});

      // Fairness: units 0 and 2 keep requesting
      set_req(UNIT_ALU, ftag[0], fdata[0], 0, 0);
      set_req(UNIT_MUL, ftag[1], fdata[1], 0, 0);
      for (int k = 0; k < 4; k++) begin
         u = (k % 2 == 0) ? 0 : 2;
         @(negedge clock);
         chk("rr_fair", 64'(req_ready), 64'(1) << u);
         exp_push(ftag[k], fdata[k], 0, 0, u);
         @(posedge clock);
         #1;
         if (k < 2) set_req(u, ftag[k+2], fdata[k+2], 0, 0);
         else req_valid[u] = 1'b0;
      end

      // Wrap: pointer at 3, lone unit 3, then pointer must be back at 0
      set_req(UNIT_DIV, 15, 150, 0, 1);
      exp_push(15, 150, 0, 1, 3);
      run_drain(4);
      chk_grants("wrap_order", 1, {4'd3});
      set_req(UNIT_ALU, 16, 160, 0, 0);
      set_req(UNIT_DIV, 17, 170, 0, 0);
      exp_push(16, 160, 0, 0, 0);
      exp_push(17, 170, 0, 0, 3);
      run_drain(6);
      chk_grants("wrap_ptr0", 2, {4'd0, 4'd3});

      idle(3);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the Common Data Bus that feeds the ROB write-back port (Cdb_rd_tag/Cdb_valid/Cdb_data/Cdb_branch/Cdb_branch_taken).
- Shares the single CDB between four completing execution units: 0 = integer ALU, 1 = load/store, 2 = multiplier, 3 = divider.
- Grants at most one result per cycle using a valid/ready handshake and drives the registered CDB outputs to the ROB and reservation stations.

Parameters:
- NREQ, 4, number of requesters; the round-robin pointer is clog2(NREQ) bits.
- TAG_W, 5, ROB tag width; matches Dispatch_Rd_tag.
- DATA_W, 32, result data width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  mispredict flush; no grant in this cycle.
- req_valid  input  NREQ  per-unit result pending.
- req_tag  input  NREQ*TAG_W  packed ROB tags; unit i occupies bits [i*TAG_W +: TAG_W].
- req_data  input  NREQ*DATA_W  packed result data.
- req_branch  input  NREQ  result belongs to a branch.
- req_branch_taken  input  NREQ  branch outcome.
- req_ready  output  NREQ  one-hot grant, combinational in the same cycle.
- Cdb_valid  output  1  broadcast valid.
- Cdb_rd_tag  output  TAG_W  broadcast tag.
- Cdb_data  output  DATA_W  broadcast data.
- Cdb_branch  output  1  broadcast branch flag.
- Cdb_branch_taken  output  1  broadcast branch outcome.
- Cdb_src  output  2  index of the granted unit (debug/trace).

Behaviour:
- Reset (asynchronous, active-high): all Cdb_* outputs = 0, rr_ptr = 0. req_ready is 0 while reset is asserted.
- Handshake:
  - A unit asserts req_valid[i] and holds its payload stable until the cycle in which req_ready[i] = 1.
  - A transfer occurs on a rising edge where req_valid[i] & req_ready[i] = 1.
  - A unit may drop req_valid only after its transfer.
- Grant selection (combinational):
  - If flush = 1, or no req_valid is set, then req_ready = 0.
  - Otherwise req_ready is one-hot on the first valid index found scanning rr_ptr, rr_ptr+1, … mod NREQ.
- Pointer update:
  - On a transfer by unit g: rr_ptr <= (g+1) mod NREQ.
  - With no transfer, rr_ptr holds.
  - This bounds any requester's wait to NREQ-1 grant cycles while it stays valid.
- Output register (latency 1):
  - The cycle after a transfer by g: Cdb_valid = 1, Cdb_rd_tag/Cdb_data/Cdb_branch/Cdb_branch_taken = payload of g, Cdb_src = g.
  - The cycle after a non-transfer: Cdb_valid = 0, and the other Cdb_* outputs hold their last values. Consumers must qualify everything with Cdb_valid.
- Back-to-back: a transfer is possible every cycle, giving a sustained throughput of one result per clock.
- Simultaneous requests: exactly one grant per cycle. Non-granted units keep valid and are served in later cycles.
- flush:
  - No transfer in that cycle; Cdb_valid = 0 on the next cycle; rr_ptr is unchanged.
  - Pending req_valid from units is the units' responsibility to clear.
  - An already-registered broadcast (Cdb_valid = 1 during the flush cycle) is not suppressed.
- Single requester: granted in the same cycle it asserts valid, regardless of rr_ptr.
- Pointer wrap: a grant to unit NREQ-1 sets rr_ptr = 0.
- Reset mid-operation: Cdb_valid drops to 0 immediately (asynchronously); pending requests are re-arbitrated from rr_ptr = 0 after reset release.
- Tag/data values are passed through unmodified; no width arithmetic is performed.

Decomposition:
- Shared package (cpu_pkg): TAG_W = 5, DATA_W = 32, NREQ = 4, unit index constants (UNIT_ALU = 0, UNIT_LS = 1, UNIT_MUL = 2, UNIT_DIV = 3), and a cdb_bus struct/typedef {valid, tag, data, branch, taken}.
- One sub-module: rr_pick, a purely combinational rotate / priority-encode / rotate-back that returns the one-hot grant and its index. Pointer state and the output register remain in cdb_arbiter.

Test Plan:
- Reset: assert reset mid-cycle while unit 0 is requesting -> Cdb_valid = 0 immediately; after release, unit 0 tag = 7 / data = 70 appears with Cdb_valid = 1 exactly one cycle after its grant.
- All four valid with tags 1/2/3/4 and data 10/20/30/40, held until served -> grants in order 0,1,2,3 on consecutive cycles; CDB shows tags 1,2,3,4 on the next four cycles; rr_ptr ends at 0.
- Round-robin fairness: units 0 and 2 continuously valid -> grants alternate 0,2,0,2; neither waits more than 1 cycle.
- Branch pass-through: unit 0 only, req_branch = 1, req_branch_taken = 1, tag = 9 -> next cycle Cdb_branch = 1, Cdb_branch_taken = 1, Cdb_rd_tag = 9, Cdb_src = 0.
- Flush: units 1 and 3 valid, flush = 1 for one cycle -> req_ready = 0 and Cdb_valid = 0 on the following cycle; after flush deasserts, unit 1 is granted first (rr_ptr unchanged at 1).
- Wrap and stability: only unit 3 valid with rr_ptr = 3 -> grant to 3, rr_ptr = 0; a bench assertion checks the payload is stable while valid & !ready and that req_ready is never more than one-hot.
